// File: rtl/axis_stereo_depacketizer.sv
// -----------------------------------------------------------------------------
// axis_stereo_depacketizer
//
// Purpose:
//   Accepts the 2-word stereo packets produced by the I2S receive controller
//   (left word first, right word flagged with last, 24-bit sample in [23:0]),
//   sign-extends each sample to OUT_W bits and queues the resulting L/R pairs
//   in a small FIFO. The consumer sees one parallel valid/ready interface.
//   The input side never stalls: when the FIFO is full a completed pair is
//   dropped and counted instead, so the source never tears a frame.
//   Framing violations (a last on the first word, or a missing last on the
//   second word) raise a one-cycle frame_err pulse.
//
// Ports:
//   axis_clk      in   system clock
//   axis_resetn   in   asynchronous active-low reset
//   s_axis_data   in   packet word, [23:0] = sample, [31:24] ignored
//   s_axis_valid  in   word valid
//   s_axis_ready  out  word accepted when valid && ready (1 after reset)
//   s_axis_last   in   marks the right-channel (second) word
//   m_sample_l    out  left sample, two's complement, OUT_W bits
//   m_sample_r    out  right sample, two's complement, OUT_W bits
//   m_valid       out  a pair is available at the FIFO head
//   m_ready       in   consumer accepts the head pair
//   fifo_level    out  number of stored pairs
//   frame_err     out  one-cycle pulse after an offending beat
//   drop_count    out  saturating count of pairs dropped on a full FIFO
// -----------------------------------------------------------------------------
module axis_stereo_depacketizer #(
    parameter int OUT_W      = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          axis_clk,
    input  logic                          axis_resetn,
    input  logic [31:0]                   s_axis_data,
    input  logic                          s_axis_valid,
    output logic                          s_axis_ready,
    input  logic                          s_axis_last,
    output logic [OUT_W-1:0]              m_sample_l,
    output logic [OUT_W-1:0]              m_sample_r,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          frame_err,
    output logic [15:0]                   drop_count
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int PAIR_W = 2 * OUT_W;

    typedef enum logic {
        WAIT_L = 1'b0,
        WAIT_R = 1'b1
    } state_t;

    // Sign-extend a 24-bit sample from bit 23 up to OUT_W bits.
    function automatic logic [OUT_W-1:0] sext(input logic [23:0] s);
        logic [OUT_W-1:0] r;
        r = '0;
        r[23:0] = s;
        for (int i = 24; i < OUT_W; i++) begin
            r[i] = s[23];
        end
        return r;
    endfunction

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Upper data byte carries nothing for this block.
    logic unused_data_hi;
    assign unused_data_hi = &{1'b0, s_axis_data[31:24]};

    // -------------------------------------------------------------------------
    // Input framing FSM
    // -------------------------------------------------------------------------
    state_t            state_q, state_d;
    logic [OUT_W-1:0]  hold_l_q, hold_l_d;
    logic              ready_q;
    logic              frame_err_q, frame_err_d;
    logic              beat;
    logic [OUT_W-1:0]  in_sext;
    logic              pair_vld;
    logic [PAIR_W-1:0] pair_data;

    assign beat      = s_axis_valid && ready_q;
    assign in_sext   = sext(s_axis_data[23:0]);
    assign pair_data = {hold_l_q, in_sext};

    always_comb begin
        state_d     = state_q;
        hold_l_d    = hold_l_q;
        pair_vld    = 1'b0;
        frame_err_d = 1'b0;
        if (beat) begin
            case (state_q)
                WAIT_L: begin
                    if (s_axis_last) begin
                        // A right word with no left before it is discarded.
                        frame_err_d = 1'b1;
                    end else begin
                        hold_l_d = in_sext;
                        state_d  = WAIT_R;
                    end
                end
                WAIT_R: begin
                    if (s_axis_last) begin
                        pair_vld = 1'b1;
                        state_d  = WAIT_L;
                    end else begin
                        // Missing last: the newest word becomes the left sample.
                        frame_err_d = 1'b1;
                        hold_l_d    = in_sext;
                    end
                end
                default: state_d = WAIT_L;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Pair FIFO
    // -------------------------------------------------------------------------
    logic [PAIR_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]  level_q, level_d;
    logic [15:0]       drop_q, drop_d;
    logic              full, empty, push, pop, drop;
    logic [PAIR_W-1:0] head;

    assign full  = (level_q == LVL_W'(FIFO_DEPTH));
    assign empty = (level_q == '0);
    assign pop   = !empty && m_ready;
    // A pop on the same edge frees the slot, so a full FIFO can still accept.
    assign push  = pair_vld && (!full || pop);
    assign drop  = pair_vld && !push;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        drop_d   = drop_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
        if (drop) begin
            drop_d = sat_inc(drop_q);
        end
    end

    always_ff @(posedge axis_clk or negedge axis_resetn) begin
        if (!axis_resetn) begin
            state_q     <= WAIT_L;
            hold_l_q    <= '0;
            ready_q     <= 1'b0;
            frame_err_q <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            drop_q      <= '0;
        end else begin
            state_q     <= state_d;
            hold_l_q    <= hold_l_d;
            ready_q     <= 1'b1;
            frame_err_q <= frame_err_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            drop_q      <= drop_d;
        end
    end

    // Storage holds data only; its contents are qualified by the level.
    always_ff @(posedge axis_clk) begin
        if (push) begin
            mem[wr_ptr_q] <= pair_data;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign head         = mem[rd_ptr_q];
    // Samples read as zero whenever nothing valid is at the head (incl. reset).
    assign m_sample_l   = empty ? '0 : head[PAIR_W-1:OUT_W];
    assign m_sample_r   = empty ? '0 : head[OUT_W-1:0];
    assign m_valid      = !empty;
    assign s_axis_ready = ready_q;
    assign fifo_level   = level_q;
    assign frame_err    = frame_err_q;
    assign drop_count   = drop_q;

endmodule

// File: tb/tb_axis_stereo_depacketizer.sv
module tb_axis_stereo_depacketizer;

    logic        clk;
    logic        rst_n;
    logic [31:0] s_data;
    logic        s_valid;
    logic        s_ready;
    logic        s_last;
    logic [31:0] m_l;
    logic [31:0] m_r;
    logic        m_valid;
    logic        m_ready;
    logic [2:0]  fifo_level;
    logic        frame_err;
    logic [15:0] drop_count;

    int errors = 0;
    int checks = 0;

    logic [63:0] sb[$];
    logic        mdl_st;
    logic [31:0] mdl_hold;
    logic [15:0] mdl_drops;

    axis_stereo_depacketizer #(
        .OUT_W(32),
        .FIFO_DEPTH(4)
    ) dut (
        .axis_clk    (clk),
        .axis_resetn (rst_n),
        .s_axis_data (s_data),
        .s_axis_valid(s_valid),
        .s_axis_ready(s_ready),
        .s_axis_last (s_last),
        .m_sample_l  (m_l),
        .m_sample_r  (m_r),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .fifo_level  (fifo_level),
        .frame_err   (frame_err),
        .drop_count  (drop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Scoreboard side: a handshake seen here completes on the next rising edge.
    always @(negedge clk) begin
        if (rst_n && m_valid && m_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_pair", {m_l, m_r}, 64'h0);
            end else begin
                check("pair", {m_l, m_r}, sb.pop_front());
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Send one word and advance the reference framing model.
    task automatic send_word(input logic [31:0] d, input logic last);
        logic        exp_fe;
        logic [31:0] sx;
        s_data  = d;
        s_last  = last;
        s_valid = 1'b1;
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        s_last  = 1'b0;
        sx      = {{8{d[23]}}, d[23:0]};
        exp_fe  = 1'b0;
        if (!mdl_st) begin
            if (last) exp_fe = 1'b1;
            else begin
                mdl_hold = sx;
                mdl_st   = 1'b1;
            end
        end else if (last) begin
            mdl_st = 1'b0;
            if (sb.size() < 4) sb.push_back({mdl_hold, sx});
            else if (mdl_drops != 16'hFFFF) mdl_drops++;
        end else begin
            exp_fe   = 1'b1;
            mdl_hold = sx;
        end
        check("frame_err", {63'd0, frame_err}, {63'd0, exp_fe});
    endtask

    task automatic send_pair(input logic [31:0] l, input logic [31:0] r);
        send_word(l, 1'b0);
        send_word(r, 1'b1);
    endtask

    task automatic drain();
        int n;
        m_ready = 1'b1;
        n = 0;
        while ((sb.size() != 0 || m_valid) && n < 50) begin
            cyc(1);
            n++;
        end
        if (n >= 50) check("drain_timeout", 64'd1, 64'd0);
        m_ready = 1'b0;
        check("level_after_drain", {61'd0, fifo_level}, 64'd0);
        check("drops", {48'd0, drop_count}, {48'd0, mdl_drops});
    endtask

    // Asynchronous reset assert between clock edges, released after one edge.
    task automatic do_reset();
        #1;
        rst_n = 1'b0;
        #1;
        check("rst_ready", {63'd0, s_ready}, 64'd0);
        check("rst_valid", {63'd0, m_valid}, 64'd0);
        check("rst_samples", {m_l, m_r}, 64'd0);
        check("rst_level", {61'd0, fifo_level}, 64'd0);
        check("rst_fe_drop", {47'd0, frame_err, drop_count}, 64'd0);
        sb.delete();
        mdl_st    = 1'b0;
        mdl_hold  = '0;
        mdl_drops = '0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc(1);
        check("ready_after_rst", {63'd0, s_ready}, 64'd1);
    endtask

    initial begin
        rst_n   = 1'b1;
        s_data  = '0;
        s_valid = 1'b0;
        s_last  = 1'b0;
        m_ready = 1'b0;
        mdl_st    = 1'b0;
        mdl_hold  = '0;
        mdl_drops = '0;
        cyc(2);
        do_reset();

        // Single packet, latency and sign extension.
        send_pair(32'h00123456, 32'h00FEDCBA);
        check("t1_valid", {63'd0, m_valid}, 64'd1);
        check("t1_pair", {m_l, m_r}, 64'h00123456_FFFEDCBA);
        check("t1_level", {61'd0, fifo_level}, 64'd1);
        drain();

        // Six packets into a 4-deep FIFO with no consumer.
        for (int i = 0; i < 6; i++) begin
            send_pair(32'h00000010 + 32'(i), 32'h00800000 + 32'(i * 3));
        end
        check("t2_level", {61'd0, fifo_level}, 64'd4);
        check("t2_drops", {48'd0, drop_count}, 64'd2);
        cyc(3);
        check("t2_head_stable", {m_l, m_r}, 64'h00000010_FF800000);
        drain();

        // Full FIFO with a pop on the same edge as the completing right word.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            send_pair(32'h00400000 + 32'(i), 32'h00000700 + 32'(i));
        end
        send_word(32'h00055555, 1'b0);
        m_ready = 1'b1;
        send_word(32'h00F0000F, 1'b1);
        m_ready = 1'b0;
        check("t3_level", {61'd0, fifo_level}, 64'd4);
        check("t3_drops", {48'd0, drop_count}, 64'd0);
        drain();

        // Last on a left slot.
        send_word(32'h00000001, 1'b1);
        cyc(1);
        check("t4_fe_pulse_end", {63'd0, frame_err}, 64'd0);
        check("t4_no_pair", {63'd0, m_valid}, 64'd0);
        send_pair(32'hAB7FFFFF, 32'h12800000);
        drain();

        // Missing last: second left replaces the first.
        send_word(32'h00000111, 1'b0);
        send_word(32'h00000222, 1'b0);
        send_word(32'h00000333, 1'b1);
        check("t5_pair", {m_l, m_r}, 64'h00000222_00000333);
        drain();

        // Reset between left and right; a lone right afterwards is a framing error.
        send_word(32'h00ABCDEF, 1'b0);
        do_reset();
        send_word(32'h00000444, 1'b1);
        cyc(3);
        check("t6_no_stale", {63'd0, m_valid}, 64'd0);
        send_pair(32'h00000555, 32'h00FFFFFF);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
